// File: rtl/uart_rx_if.sv
// Receive-side handshake bundle of the 8N1 UART receiver: byte holding register,
// valid/ready acceptance, error pulses and busy indication.
interface uart_rx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_frame_err;
    logic                 rx_overrun;
    logic                 rx_busy;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_frame_err,
        output rx_overrun,
        output rx_busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  rx_frame_err,
        input  rx_overrun,
        input  rx_busy,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF line synchroniser, mid-bit sampling FSM and a one-entry
// valid/ready holding register with single-cycle framing-error and overrun pulses.
module uart_rx #(
    parameter int unsigned CLK_HZ    = 12000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic      CLK12M,
    input  logic      RESET,
    input  logic      BDBUS0,
    uart_rx_if.master rx
);
    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned HALF         = CLKS_PER_BIT / 2;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW           = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT
    } state_t;

    logic                 sync1_q, sync2_q;
    logic                 rxs;
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 fe_q, fe_d;
    logic                 ov_q, ov_d;
    logic                 deliver;

    assign rxs = sync2_q;

    always_ff @(posedge CLK12M or negedge RESET) begin
        if (!RESET) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            sync1_q <= BDBUS0;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        fe_d    = 1'b0;
        deliver = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    // A start bit that is gone by mid-bit is treated as a glitch.
                    if (!rxs) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        bit_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                    cnt_d   = '0;
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d = '0;
                    if (rxs) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = S_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Holding register: a same-cycle accept frees the slot for the new byte.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ov_d    = 1'b0;
        if (deliver) begin
            if (!valid_q || rx.rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end else if (valid_q && rx.rx_ready) begin
            valid_d = 1'b0;
        end
    end

    assign rx.rx_data      = data_q;
    assign rx.rx_valid     = valid_q;
    assign rx.rx_frame_err = fe_q;
    assign rx.rx_overrun   = ov_q;
    assign rx.rx_busy      = (state_q != S_IDLE);
endmodule
